twin_elevator_dispatcher: RTL and testbench
===========================================

Name: twin_elevator_dispatcher

Overview:
Hall-call dispatcher for the twin-elevator system. It latches floor call requests into a pending set and picks which car serves each call, using nearest idle car first with round-robin tie-break. It issues one destination at a time to the chosen car's drive controller and holds the call until that car acknowledges by going busy. It sits between the keypad/call decode logic and the two per-car queue/drive pairs, replacing direct call-to-car steering.

Parameters:
NUM_FLOORS, 4, number of floors; floor codes are one-hot NUM_FLOORS bits
ACK_TIMEOUT, 16, clk cycles to wait for car acknowledge before re-arbitrating

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
call_valid  input  1  one-cycle call strobe
call_floor  input  NUM_FLOORS  one-hot requested floor
cur1  input  NUM_FLOORS  car 1 current floor, one-hot
cur2  input  NUM_FLOORS  car 2 current floor, one-hot
busy1  input  1  car 1 moving or has a destination (acknowledge)
busy2  input  1  car 2 moving or has a destination (acknowledge)
dest1  output  NUM_FLOORS  destination to car 1, valid with go1
go1  output  1  one-cycle issue pulse to car 1
dest2  output  NUM_FLOORS  destination to car 2, valid with go2
go2  output  1  one-cycle issue pulse to car 2
pending  output  NUM_FLOORS  outstanding calls, one bit per floor
call_err  output  1  one-cycle pulse: call_floor zero or not one-hot

Behaviour:
- Reset (async, rst_n=0): pending=0, dest1=dest2=0, go1=go2=0, call_err=0, FSM=IDLE, rr_favor=car1, timeout counter=0.
- Call capture, every cycle: call_valid with a legal one-hot code sets the pending bit on the next edge, unless that floor equals cur of an idle car (busy=0). In that case the call counts as served and is dropped. A duplicate of a pending floor has no effect. An illegal code gives call_err=1 for one cycle and pending stays unchanged.
- FSM states: IDLE, SELECT, ISSUE, WAIT_ACK.
- IDLE -> SELECT when pending!=0 and (busy1=0 or busy2=0).
- SELECT, one cycle:
  - Target = lowest-index set pending bit.
  - Distance = |index(target) - index(cur)| for each idle car.
  - Only one car idle: choose it.
  - Both idle: choose the smaller distance. On a tie choose rr_favor, then toggle rr_favor.
  - If no car is idle now, return to IDLE.
- ISSUE, one cycle:
  - go of the chosen car = 1 and its dest = target; the other car's go = 0.
  - dest holds its value until the next issue to that car.
  - Next state WAIT_ACK; clear the counter.
- WAIT_ACK:
  - Chosen car's busy=1: clear the target's pending bit, go to IDLE.
  - Counter reaches ACK_TIMEOUT-1: keep the pending bit, go to IDLE for a retry.
  - Otherwise increment the counter.
- Issue latency: 3 clk from the pending bit set with both cars idle to the go pulse (IDLE, SELECT, ISSUE edges).
- At most one go pulse every 3 cycles. go1 and go2 are never both high.
- Simultaneous events:
  - New call in the same cycle as a pending clear: both updates apply, on different bits.
  - A call for the target floor during WAIT_ACK has no effect; the bit stays set.
  - A call for the target floor in the same cycle as its clear: the clear wins.
- Distance arithmetic: floor index is 2 bits (log2 NUM_FLOORS), unsigned; absolute difference is computed by comparing the indices, with no wrap.
- cur not one-hot, from a car between floors: that car is treated as not idle for selection.
- Reset mid-operation clears everything immediately, and any go in flight is dropped.

Decomposition:
- Package twin_elevator_pkg:
  - NUM_FLOORS default.
  - floor_t (one-hot logic vector).
  - Dispatcher state enum: IDLE, SELECT, ISSUE, WAIT_ACK.
  - car_sel_t: CAR1, CAR2.
  - Function onehot_to_idx returning 2-bit index plus a valid flag.
- One sub-module, car_selector: combinational.
  - Inputs: target, cur1, cur2, busy1, busy2, rr_favor.
  - Outputs: sel, sel_valid, tie.
  - The FSM registers sel in SELECT.

Test Plan:
- Reset, then call_floor=0100 with cur1=0001, cur2=1000, both idle -> go2=1, dest2=0100 exactly 3 clk after the pending bit sets; busy2=1 next cycle -> pending returns to 0000.
- Both cars at 0001, idle, calls 0100 then 0100 -> first go to car1 (rr_favor reset); after ack and car1 back idle at 0001, next tie goes to car2.
- call_floor=0110 -> call_err pulses 1 cycle, pending stays 0000; call_floor=0001 with idle car1 at 0001 -> pending stays 0000, no go.
- Car1 idle, car2 busy, call 1000 issued to car1 with busy1 held 0 -> after ACK_TIMEOUT=16 cycles, re-issue go1 again; pending[3] stays 1 throughout.
- Calls 0010 and 1000 in consecutive cycles, both cars busy -> pending=1010, no go; drop busy1 -> floor 0010 served first.
- Assert rst_n=0 during WAIT_ACK -> all outputs 0 asynchronously, FSM IDLE; no go after release until a new call.

Source files
------------

// File: rtl/twin_elevator_pkg.sv
// Shared types for the twin-elevator hall-call dispatcher.
// Floor codes are one-hot; indices are log2(NUM_FLOORS) bits.
package twin_elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int IDX_W      = $clog2(NUM_FLOORS);

    typedef logic [NUM_FLOORS-1:0] floor_t;
    typedef logic [IDX_W-1:0]      idx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        ISSUE    = 2'd2,
        WAIT_ACK = 2'd3
    } disp_state_e;

    typedef enum logic {
        CAR1 = 1'b0,
        CAR2 = 1'b1
    } car_sel_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } oh_idx_t;

    function automatic oh_idx_t onehot_to_idx(floor_t f);
        oh_idx_t r;
        r.valid = $onehot(f);
        r.idx   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (f[i]) r.idx = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/twin_elevator_dispatcher_if.sv
// Call input, car status and car command bundle between
// the call decode / car drive side and the dispatcher.
interface twin_elevator_dispatcher_if;
    import twin_elevator_pkg::*;

    logic   call_valid;
    floor_t call_floor;
    floor_t cur1;
    floor_t cur2;
    logic   busy1;
    logic   busy2;
    floor_t dest1;
    logic   go1;
    floor_t dest2;
    logic   go2;
    floor_t pending;
    logic   call_err;

    modport master (
        output call_valid, call_floor, cur1, cur2, busy1, busy2,
        input  dest1, go1, dest2, go2, pending, call_err
    );

    modport slave (
        input  call_valid, call_floor, cur1, cur2, busy1, busy2,
        output dest1, go1, dest2, go2, pending, call_err
    );

endinterface

// File: rtl/twin_elevator_dispatcher_car_selector.sv
// Picks the car for a target floor: nearest idle car,
// round-robin favourite on an equal-distance tie.
module car_selector
    import twin_elevator_pkg::*;
(
    input  floor_t   i_target,
    input  floor_t   i_cur1,
    input  floor_t   i_cur2,
    input  logic     i_busy1,
    input  logic     i_busy2,
    input  car_sel_t i_rr_favor,
    output car_sel_t o_sel,
    output logic     o_sel_valid,
    output logic     o_tie
);

    oh_idx_t w_t;
    oh_idx_t w_c1;
    oh_idx_t w_c2;
    idx_t    w_d1;
    idx_t    w_d2;
    logic    w_idle1;
    logic    w_idle2;

    assign w_t  = onehot_to_idx(i_target);
    assign w_c1 = onehot_to_idx(i_cur1);
    assign w_c2 = onehot_to_idx(i_cur2);

    // A car between floors has no legal position and cannot be chosen.
    assign w_idle1 = !i_busy1 && w_c1.valid;
    assign w_idle2 = !i_busy2 && w_c2.valid;

    assign w_d1 = (w_t.idx >= w_c1.idx) ? w_t.idx - w_c1.idx
                                        : w_c1.idx - w_t.idx;
    assign w_d2 = (w_t.idx >= w_c2.idx) ? w_t.idx - w_c2.idx
                                        : w_c2.idx - w_t.idx;

    always_comb begin
        o_sel       = CAR1;
        o_sel_valid = 1'b0;
        o_tie       = 1'b0;
        unique case (1'b1)
            (w_idle1 && w_idle2): begin
                o_sel_valid = w_t.valid;
                if (w_d1 < w_d2) begin
                    o_sel = CAR1;
                end else if (w_d2 < w_d1) begin
                    o_sel = CAR2;
                end else begin
                    o_sel = i_rr_favor;
                    o_tie = w_t.valid;
                end
            end
            (w_idle1 && !w_idle2): begin
                o_sel       = CAR1;
                o_sel_valid = w_t.valid;
            end
            (!w_idle1 && w_idle2): begin
                o_sel       = CAR2;
                o_sel_valid = w_t.valid;
            end
            default: begin
                o_sel_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/twin_elevator_dispatcher.sv
// Hall-call dispatcher: latches calls into a pending set and issues
// one destination at a time to the selected car, waiting for its ack.
module twin_elevator_dispatcher
    import twin_elevator_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
)(
    input logic                     clk,
    input logic                     rst_n,
    twin_elevator_dispatcher_if.slave bus
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_SELECT = 2'(SELECT);
    localparam logic [1:0] ST_ISSUE  = 2'(ISSUE);
    localparam logic [1:0] ST_WAIT   = 2'(WAIT_ACK);

    logic [1:0]       r_state;
    floor_t           r_pending;
    floor_t           r_target;
    floor_t           r_dest1;
    floor_t           r_dest2;
    logic             r_go1;
    logic             r_go2;
    logic             r_err;
    car_sel_t         r_sel;
    car_sel_t         r_rr;
    logic [CNT_W-1:0] r_cnt;

    logic     w_legal;
    logic     w_served;
    floor_t   w_set;
    floor_t   w_clr;
    floor_t   w_target;
    logic     w_busy_sel;
    logic     w_ack;
    car_sel_t w_sel;
    logic     w_sel_valid;
    logic     w_tie;

    assign w_legal  = $onehot(bus.call_floor);
    assign w_served = (bus.call_floor == bus.cur1 && !bus.busy1) ||
                      (bus.call_floor == bus.cur2 && !bus.busy2);
    assign w_set    = (bus.call_valid && w_legal && !w_served)
                      ? bus.call_floor : '0;

    // Isolate the lowest set pending bit.
    assign w_target = r_pending & (~r_pending + floor_t'(1));

    assign w_busy_sel = (r_sel == CAR1) ? bus.busy1 : bus.busy2;
    assign w_ack      = (r_state == ST_WAIT) && w_busy_sel;
    assign w_clr      = w_ack ? r_target : '0;

    car_selector u_sel (
        .i_target    (w_target),
        .i_cur1      (bus.cur1),
        .i_cur2      (bus.cur2),
        .i_busy1     (bus.busy1),
        .i_busy2     (bus.busy2),
        .i_rr_favor  (r_rr),
        .o_sel       (w_sel),
        .o_sel_valid (w_sel_valid),
        .o_tie       (w_tie)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_target  <= '0;
            r_dest1   <= '0;
            r_dest2   <= '0;
            r_go1     <= 1'b0;
            r_go2     <= 1'b0;
            r_err     <= 1'b0;
            r_sel     <= CAR1;
            r_rr      <= CAR1;
            r_cnt     <= '0;
        end else begin
            r_pending <= (r_pending | w_set) & ~w_clr;
            r_err     <= bus.call_valid && !w_legal;
            r_go1     <= 1'b0;
            r_go2     <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (|r_pending && (!bus.busy1 || !bus.busy2))
                        r_state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (w_sel_valid) begin
                        r_sel    <= w_sel;
                        r_target <= w_target;
                        if (w_tie)
                            r_rr <= (r_rr == CAR1) ? CAR2 : CAR1;
                        r_state  <= ST_ISSUE;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (r_sel == CAR1) begin
                        r_go1   <= 1'b1;
                        r_dest1 <= r_target;
                    end else begin
                        r_go2   <= 1'b1;
                        r_dest2 <= r_target;
                    end
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A timeout leaves the call pending for a fresh arbitration.
                    if (w_busy_sel || r_cnt == CNT_MAX)
                        r_state <= ST_IDLE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dest1    = r_dest1;
    assign bus.go1      = r_go1;
    assign bus.dest2    = r_dest2;
    assign bus.go2      = r_go2;
    assign bus.pending  = r_pending;
    assign bus.call_err = r_err;

endmodule

// File: tb/tb_twin_elevator_dispatcher.sv
// Directed bench for twin_elevator_dispatcher: inputs driven and
// outputs sampled on the falling clock edge.
module tb_twin_elevator_dispatcher;
    import twin_elevator_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    twin_elevator_dispatcher_if bus ();

    twin_elevator_dispatcher #(.ACK_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int  k;
        int  go_at;
        logic held;
        logic any_go;

        n_checks = 0;
        n_err    = 0;
        rst_n          = 1'b0;
        bus.call_valid = 1'b0;
        bus.call_floor = 4'b0000;
        bus.cur1       = 4'b0001;
        bus.cur2       = 4'b1000;
        bus.busy1      = 1'b0;
        bus.busy2      = 1'b0;

        // Reset state
        cyc(2);
        chk("rst_pending", 8'(bus.pending), 8'h0);
        chk("rst_go", 8'({bus.go1, bus.go2}), 8'h0);
        chk("rst_dest", 8'({bus.dest1, bus.dest2}), 8'h0);
        chk("rst_err", 8'(bus.call_err), 8'h0);
        rst_n = 1'b1;

        // Nearest car: car2 at floor 3 is closer to floor 2
        cyc(1);
        bus.call_valid = 1'b1;
        bus.call_floor = 4'b0100;
        cyc(1);
        bus.call_valid = 1'b0;
        chk("t1_pending", 8'(bus.pending), 8'h4);
        cyc(1);
        chk("t1_go_c1", 8'({bus.go1, bus.go2}), 8'h0);
        cyc(1);
        chk("t1_go_c2", 8'({bus.go1, bus.go2}), 8'h0);
        cyc(1);
        chk("t1_go_c3", 8'({bus.go1, bus.go2}), 8'h1);
        chk("t1_dest2", 8'(bus.dest2), 8'h4);
        bus.busy2 = 1'b1;
        cyc(1);
        chk("t1_clear", 8'(bus.pending), 8'h0);
        chk("t1_go_off", 8'({bus.go1, bus.go2}), 8'h0);
        bus.busy2 = 1'b0;
        bus.cur2  = 4'b0001;
        bus.cur1  = 4'b0001;

        // Tie: first to car1, then round-robin to car2
        cyc(1);
        bus.call_valid = 1'b1;
        bus.call_floor = 4'b0100;
        cyc(1);
        bus.call_valid = 1'b0;
        cyc(3);
        chk("t2_go_a", 8'({bus.go1, bus.go2}), 8'h2);
        chk("t2_dest1", 8'(bus.dest1), 8'h4);
        bus.busy1 = 1'b1;
        cyc(1);
        chk("t2_clear_a", 8'(bus.pending), 8'h0);
        bus.busy1 = 1'b0;
        cyc(1);
        bus.call_valid = 1'b1;
        bus.call_floor = 4'b0100;
        cyc(1);
        bus.call_valid = 1'b0;
        cyc(3);
        chk("t2_go_b", 8'({bus.go1, bus.go2}), 8'h1);
        chk("t2_dest2", 8'(bus.dest2), 8'h4);
        chk("t2_dest1_hold", 8'(bus.dest1), 8'h4);
        bus.busy2 = 1'b1;
        cyc(1);
        chk("t2_clear_b", 8'(bus.pending), 8'h0);
        bus.busy2 = 1'b0;

        // Illegal code, then a call served by an idle car in place
        cyc(1);
        bus.call_valid = 1'b1;
        bus.call_floor = 4'b0110;
        cyc(1);
        bus.call_valid = 1'b0;
        chk("t3_err", 8'(bus.call_err), 8'h1);
        chk("t3_pending", 8'(bus.pending), 8'h0);
        cyc(1);
        chk("t3_err_pulse", 8'(bus.call_err), 8'h0);
        bus.call_valid = 1'b1;
        bus.call_floor = 4'b0001;
        cyc(1);
        bus.call_valid = 1'b0;
        chk("t3_drop", 8'(bus.pending), 8'h0);
        any_go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            any_go = any_go | bus.go1 | bus.go2;
        end
        chk("t3_no_go", 8'(any_go), 8'h0);

        // Ack timeout: re-issue to car1, call stays pending
        bus.busy2 = 1'b1;
        bus.call_valid = 1'b1;
        bus.call_floor = 4'b1000;
        cyc(1);
        bus.call_valid = 1'b0;
        cyc(3);
        chk("t4_go1", 8'({bus.go1, bus.go2}), 8'h2);
        chk("t4_dest1", 8'(bus.dest1), 8'h8);
        held  = 1'b1;
        go_at = 0;
        k     = 0;
        while (go_at == 0 && k < 30) begin
            cyc(1);
            k++;
            held = held & bus.pending[3];
            if (bus.go1) go_at = k;
        end
        chk("t4_held", 8'(held), 8'h1);
        chk("t4_retry_at", 8'(go_at), 8'd19);
        bus.busy1 = 1'b1;
        cyc(1);
        chk("t4_clear", 8'(bus.pending), 8'h0);

        // Both busy: calls accumulate, lowest floor served first
        bus.call_valid = 1'b1;
        bus.call_floor = 4'b0010;
        cyc(1);
        bus.call_floor = 4'b1000;
        cyc(1);
        bus.call_valid = 1'b0;
        chk("t5_pending", 8'(bus.pending), 8'hA);
        any_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            any_go = any_go | bus.go1 | bus.go2;
        end
        chk("t5_no_go", 8'(any_go), 8'h0);
        bus.busy1 = 1'b0;
        cyc(3);
        chk("t5_go1", 8'({bus.go1, bus.go2}), 8'h2);
        chk("t5_dest1", 8'(bus.dest1), 8'h2);

        // Asynchronous reset while waiting for the ack
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pending", 8'(bus.pending), 8'h0);
        chk("t6_go", 8'({bus.go1, bus.go2}), 8'h0);
        chk("t6_dest", 8'({bus.dest1, bus.dest2}), 8'h0);
        chk("t6_err", 8'(bus.call_err), 8'h0);
        chk("t6_state", 8'(dut.r_state), 8'(IDLE));
        cyc(1);
        rst_n = 1'b1;
        any_go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            any_go = any_go | bus.go1 | bus.go2;
        end
        chk("t6_no_go", 8'(any_go), 8'h0);
        chk("t6_idle_pend", 8'(bus.pending), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
